sfx_voice: RTL and testbench
============================

Name: sfx_voice

Overview:
- One-shot or looping square-wave sound-effect voice in the `audio_clk` domain.
- Instantiated once per effect (UFO, shoot, player hit, alien hit, UFO hit) inside the audio path. Consumes the `play_*`/`stop_*` pulses derived from port 3/5 writes.
- Produces a 1-bit tone plus an activity flag; the audio mixer ORs/sums the voices into `audio_out`.
- Supports linear pitch sweep and fixed or infinite duration.

Parameters:
- PERIOD_WIDTH, 32, width of all period/cycle counters.
- START_PERIOD, 32'd200_000, full tone period in clk cycles loaded on play; must be ≥2.
- END_PERIOD, 32'd200_000, sweep limit; the period never moves past this value.
- SWEEP_INTERVAL, 32'd0, clk cycles between period updates; 0 disables sweep.
- SWEEP_STEP, 32'd0, unsigned period change per sweep update. Direction is up if END_PERIOD>START_PERIOD, down otherwise.
- DURATION, 32'd10_000_000, clk cycles the voice plays; 0 means loop until stop.

Ports:
- clk  input  1  audio clock
- rst  input  1  asynchronous, active-high reset
- play  input  1  single-cycle start/restart pulse
- stop  input  1  single-cycle stop pulse
- out  output  1  tone output; 0 when idle
- active  output  1  1 while in PLAY state
- period  output  PERIOD_WIDTH  current full period (debug/mixer use)

Behaviour:
- Reset (asynchronous, any time, including mid-tone) sets:
  - state=IDLE, out=0, active=0, period=START_PERIOD.
  - All counters cleared.
- States: IDLE, PLAY. All outputs are registered.
- IDLE→PLAY when play=1 and stop=0. On the next edge:
  - active=1, out=1, period=START_PERIOD.
  - half_cnt=0, sweep_cnt=0, dur_cnt=DURATION.
- PLAY, play=1 and stop=0: restart, with the same loads as IDLE→PLAY (retrigger resets pitch and duration).
- PLAY→IDLE on any of:
  - stop=1 (stop wins over a simultaneous play);
  - DURATION≠0 and dur_cnt reaches 1 (voice plays exactly DURATION cycles after the load edge).
- On the PLAY→IDLE edge: out=0, active=0. period holds its last value until the next play.
- Tone generation:
  - half_cnt counts clk cycles; when half_cnt == (period>>1)-1, toggle out and clear half_cnt.
  - Odd periods round down to an even full period.
  - A period change takes effect at the next comparison; half_cnt is not reset by a sweep. If half_cnt ≥ the new half-period, toggle on the next cycle and clear.
- Sweep (SWEEP_INTERVAL≠0):
  - sweep_cnt counts up; at SWEEP_INTERVAL-1 it clears and period steps by SWEEP_STEP toward END_PERIOD.
  - Saturate exactly at END_PERIOD; no overshoot, no wrap-around even if the step exceeds the remaining distance.
- Counters are PERIOD_WIDTH wide with no wrap; DURATION=0 holds dur_cnt at 0.
- A stop in IDLE is ignored.
- Latency: play pulse to out=1 is 1 cycle; stop to out=0 is 1 cycle.

Optional Feature:
- Macro: SFX_VOICE_NOISE_EN.
- When defined:
  - Adds a 15-bit Galois LFSR (taps x^15+x^14+1), seeded to 15'h7FFF on reset and on every play load.
  - At each half-period event the LFSR advances and out takes LFSR bit 0 instead of toggling.
  - Used for the explosion/hit voices.
- When undefined: no LFSR logic; out is the pure square wave described above.

Test Plan:
- Reset defaults. START_PERIOD=8, DURATION=40, no sweep. Assert rst mid-tone at cycle 13 → out=0, active=0, period=8 asynchronously, with no glitch after release.
- Basic tone. Same params, play pulse at t0:
  - out=1 at t0+1, toggling every 4 cycles;
  - active drops after exactly 40 cycles;
  - exactly 10 out transitions, including the final drop to 0.
- Loop and stop. DURATION=0, START_PERIOD=6, play:
  - tone persists for 1000 cycles;
  - stop → out=0, active=0 next cycle;
  - simultaneous play+stop in PLAY → IDLE.
- Upward sweep with saturation. START=10, END=17, SWEEP_INTERVAL=20, STEP=4:
  - period sequence is 10, 14, 17, 17 at 20-cycle intervals;
  - half-period toggles follow 5, 7, 8 cycles.
- Retrigger. Play, then play again 15 cycles later during a downward sweep → period=START_PERIOD, duration restarts (active lasts DURATION from the second pulse).
- Noise build (SFX_VOICE_NOISE_EN). After play, out sequence at successive half-period events matches the reference LFSR model seeded with 7FFF; a second play reproduces the identical sequence.

Source files
------------

// File: rtl/sfx_voice.sv
// Square-wave sound-effect voice: one-shot or looping tone with linear pitch sweep.
// Optional SFX_VOICE_NOISE_EN replaces the square wave with a 15-bit LFSR noise source.
module sfx_voice #(
   parameter int unsigned             PERIOD_WIDTH   = 32,
   parameter logic [PERIOD_WIDTH-1:0] START_PERIOD   = 32'd200_000,
   parameter logic [PERIOD_WIDTH-1:0] END_PERIOD     = 32'd200_000,
   parameter logic [PERIOD_WIDTH-1:0] SWEEP_INTERVAL = 32'd0,
   parameter logic [PERIOD_WIDTH-1:0] SWEEP_STEP     = 32'd0,
   parameter logic [PERIOD_WIDTH-1:0] DURATION       = 32'd10_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    play,
   input  logic                    stop,
   output logic                    out,
   output logic                    active,
   output logic [PERIOD_WIDTH-1:0] period
);

   typedef enum logic {IDLE, PLAY} state_e;

   localparam logic [PERIOD_WIDTH-1:0] ONE      = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
   localparam bit                      SWEEP_UP = (END_PERIOD > START_PERIOD);
   localparam bit                      SWEEP_EN = (SWEEP_INTERVAL != '0);
   localparam bit                      DUR_EN   = (DURATION != '0);

   state_e                  state_q;
   logic                    out_q, active_q;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic [PERIOD_WIDTH-1:0] half_cnt_q, sweep_cnt_q, dur_cnt_q;
   logic [PERIOD_WIDTH-1:0] half_w, stepped;
   logic [PERIOD_WIDTH:0]   half_cnt_inc;
   logic                    load, tone_evt, sweep_evt, dur_end;

`ifdef SFX_VOICE_NOISE_EN
   logic [14:0] lfsr_q, lfsr_d;
   always_comb lfsr_d = {1'b0, lfsr_q[14:1]} ^ (lfsr_q[0] ? 15'h6000 : 15'h0000);
`endif

   always_comb begin
      load         = play && !stop;
      half_w       = period_q >> 1;
      // A sweep may shrink the half-period below the running count: fire at once.
      half_cnt_inc = {1'b0, half_cnt_q} + {{PERIOD_WIDTH{1'b0}}, 1'b1};
      tone_evt     = half_cnt_inc >= {1'b0, half_w};
      sweep_evt    = SWEEP_EN && (sweep_cnt_q == SWEEP_INTERVAL - ONE);
      dur_end      = DUR_EN && (dur_cnt_q == ONE);
      stepped      = period_q;
      if (SWEEP_UP) begin
         if (END_PERIOD - period_q <= SWEEP_STEP) stepped = END_PERIOD;
         else                                     stepped = period_q + SWEEP_STEP;
      end else begin
         if (period_q - END_PERIOD <= SWEEP_STEP) stepped = END_PERIOD;
         else                                     stepped = period_q - SWEEP_STEP;
      end
      period_d = sweep_evt ? stepped : period_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         out_q       <= 1'b0;
         active_q    <= 1'b0;
         period_q    <= START_PERIOD;
         half_cnt_q  <= '0;
         sweep_cnt_q <= '0;
         dur_cnt_q   <= '0;
`ifdef SFX_VOICE_NOISE_EN
         lfsr_q      <= 15'h7FFF;
`endif
      end else if (load) begin
         state_q     <= PLAY;
         out_q       <= 1'b1;
         active_q    <= 1'b1;
         period_q    <= START_PERIOD;
         half_cnt_q  <= '0;
         sweep_cnt_q <= '0;
         dur_cnt_q   <= DURATION;
`ifdef SFX_VOICE_NOISE_EN
         lfsr_q      <= 15'h7FFF;
`endif
      end else if (state_q == PLAY) begin
         if (stop || dur_end) begin
            state_q  <= IDLE;
            out_q    <= 1'b0;
            active_q <= 1'b0;
         end else begin
            if (tone_evt) begin
               half_cnt_q <= '0;
`ifdef SFX_VOICE_NOISE_EN
               out_q  <= lfsr_d[0];
               lfsr_q <= lfsr_d;
`else
               out_q  <= ~out_q;
`endif
            end else begin
               half_cnt_q <= half_cnt_q + ONE;
            end
            if (sweep_evt)     sweep_cnt_q <= '0;
            else if (SWEEP_EN) sweep_cnt_q <= sweep_cnt_q + ONE;
            period_q <= period_d;
            if (DUR_EN) dur_cnt_q <= dur_cnt_q - ONE;
         end
      end
   end

   assign out    = out_q;
   assign active = active_q;
   assign period = period_q;

endmodule

// File: tb/tb_sfx_voice.sv
// Bench for sfx_voice: four differently-configured voices checked against an
// elapsed-time reference model (period as a closed-form function of time since load).
module tb_sfx_voice;

   localparam longint unsigned P_START[4] = '{8, 6, 10, 40};
   localparam longint unsigned P_END[4]   = '{8, 6, 17, 12};
   localparam longint unsigned P_INT[4]   = '{0, 0, 20, 6};
   localparam longint unsigned P_STEP[4]  = '{0, 0, 4, 5};
   localparam longint unsigned P_DUR[4]   = '{40, 0, 100, 60};

   logic        clk, rst;
   logic        play_v[4], stop_v[4], out_v[4], act_v[4];
   logic [31:0] per_v[4];

   int errors = 0;
   int checks = 0;

   bit              m_act[4], m_out[4];
   longint unsigned m_per[4], m_k[4], m_last[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sfx_voice #(
         .PERIOD_WIDTH  (32),
         .START_PERIOD  (32'(P_START[g])),
         .END_PERIOD    (32'(P_END[g])),
         .SWEEP_INTERVAL(32'(P_INT[g])),
         .SWEEP_STEP    (32'(P_STEP[g])),
         .DURATION      (32'(P_DUR[g]))
      ) u_dut (
         .clk   (clk),
         .rst   (rst),
         .play  (play_v[g]),
         .stop  (stop_v[g]),
         .out   (out_v[g]),
         .active(act_v[g]),
         .period(per_v[g])
      );
   end

   // Period after n clock edges of playing, straight from the sweep rule.
   function automatic longint unsigned psat(int i, longint unsigned n);
      longint unsigned s, e, d;
      s = P_START[i];
      e = P_END[i];
      if (P_INT[i] == 0) return s;
      d = P_STEP[i] * (n / P_INT[i]);
      if (e > s) return (s + d >= e) ? e : s + d;
      return (d >= s - e) ? e : s - d;
   endfunction

   // Reference: k = edges since load, last = edge of the latest toggle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_act[i] <= 1'b0; m_out[i] <= 1'b0; m_per[i] <= P_START[i];
            m_k[i] <= 0; m_last[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (play_v[i] && !stop_v[i]) begin
               m_act[i] <= 1'b1; m_out[i] <= 1'b1; m_per[i] <= P_START[i];
               m_k[i] <= 0; m_last[i] <= 0;
            end else if (m_act[i]) begin
               if (stop_v[i] || (P_DUR[i] != 0 && m_k[i] + 1 == P_DUR[i])) begin
                  m_act[i] <= 1'b0; m_out[i] <= 1'b0;
               end else begin
                  if (m_k[i] + 1 - m_last[i] >= (psat(i, m_k[i]) >> 1)) begin
                     m_out[i]  <= !m_out[i];
                     m_last[i] <= m_k[i] + 1;
                  end
                  m_per[i] <= psat(i, m_k[i] + 1);
                  m_k[i]   <= m_k[i] + 1;
               end
            end
         end
      end
   end

   task automatic pulse_play(input int i);
      play_v[i] = 1'b1;
      @(negedge clk);
      play_v[i] = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_v[i] !== 1'b0 || act_v[i] !== 1'b0 || 64'(per_v[i]) !== P_START[i]) begin
            errors++;
            $display("FAIL reset_defaults[%0d]: out=%b act=%b per=%0d want 0 0 %0d",
                     i, out_v[i], act_v[i], per_v[i], P_START[i]);
         end
      end
      pulse_play(0);
      repeat (12) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_v[0] !== 1'b0 || act_v[0] !== 1'b0 || per_v[0] !== 32'd8) begin
         errors++;
         $display("FAIL reset_async: out=%b act=%b per=%0d want 0 0 8", out_v[0], act_v[0], per_v[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (out_v[0] !== 1'b0 || act_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release c%0d: out=%b act=%b want 0 0", c, out_v[0], act_v[0]);
         end
      end
   endtask

   task automatic test_basic_tone();
      int trans, act_cycles;
      logic prev;
      prev = out_v[0];
      trans = 0; act_cycles = 0;
      pulse_play(0);
      checks++;
      if (out_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL basic_first_out: out=%b want 1", out_v[0]);
      end
      for (int c = 0; c < 50; c++) begin
         if (c > 0) @(negedge clk);
         if (out_v[0] !== prev) trans++;
         prev = out_v[0];
         if (act_v[0] === 1'b1) act_cycles++;
         checks++;
         if (out_v[0] !== m_out[0] || act_v[0] !== m_act[0]) begin
            errors++;
            $display("FAIL basic_model c%0d: out=%b act=%b want %b %b", c, out_v[0], act_v[0], m_out[0], m_act[0]);
         end
      end
      checks++;
      if (act_cycles != 40) begin
         errors++;
         $display("FAIL basic_duration: active cycles=%0d want 40", act_cycles);
      end
      checks++;
      if (trans != 10) begin
         errors++;
         $display("FAIL basic_transitions: got %0d want 10", trans);
      end
   endtask

   task automatic test_loop_stop();
      int trans, bad;
      logic prev;
      trans = 0; bad = 0;
      pulse_play(1);
      prev = out_v[1];
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (out_v[1] !== prev) trans++;
         prev = out_v[1];
         if (out_v[1] !== m_out[1] || act_v[1] !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0 || trans < 300) begin
         errors++;
         $display("FAIL loop_persist: bad_cycles=%0d transitions=%0d want 0 and >=300", bad, trans);
      end
      stop_v[1] = 1'b1;
      @(negedge clk);
      stop_v[1] = 1'b0;
      checks++;
      if (out_v[1] !== 1'b0 || act_v[1] !== 1'b0) begin
         errors++;
         $display("FAIL loop_stop: out=%b act=%b want 0 0", out_v[1], act_v[1]);
      end
      stop_v[1] = 1'b1;
      @(negedge clk);
      stop_v[1] = 1'b0;
      checks++;
      if (act_v[1] !== 1'b0 || 64'(per_v[1]) !== m_per[1]) begin
         errors++;
         $display("FAIL idle_stop: act=%b per=%0d want 0 %0d", act_v[1], per_v[1], m_per[1]);
      end
      pulse_play(1);
      repeat (7) @(negedge clk);
      play_v[1] = 1'b1; stop_v[1] = 1'b1;
      @(negedge clk);
      play_v[1] = 1'b0; stop_v[1] = 1'b0;
      checks++;
      if (out_v[1] !== 1'b0 || act_v[1] !== 1'b0) begin
         errors++;
         $display("FAIL play_stop_same: out=%b act=%b want 0 0", out_v[1], act_v[1]);
      end
   endtask

   task automatic test_sweep();
      longint unsigned want[4] = '{10, 14, 17, 17};
      pulse_play(2);
      for (int c = 0; c <= 60; c++) begin
         if (c > 0) @(negedge clk);
         checks++;
         if (out_v[2] !== m_out[2] || act_v[2] !== m_act[2] || 64'(per_v[2]) !== m_per[2]) begin
            errors++;
            $display("FAIL sweep_model c%0d: out=%b act=%b per=%0d want %b %b %0d",
                     c, out_v[2], act_v[2], per_v[2], m_out[2], m_act[2], m_per[2]);
         end
         if (c % 20 == 0) begin
            checks++;
            if (64'(per_v[2]) !== want[c/20]) begin
               errors++;
               $display("FAIL sweep_period t%0d: per=%0d want %0d", c, per_v[2], want[c/20]);
            end
         end
      end
      stop_v[2] = 1'b1;
      @(negedge clk);
      stop_v[2] = 1'b0;
   endtask

   task automatic test_retrigger();
      int act_cycles;
      act_cycles = 0;
      pulse_play(3);
      repeat (15) @(negedge clk);
      checks++;
      if (per_v[3] !== 32'd30) begin
         errors++;
         $display("FAIL retrig_swept: per=%0d want 30", per_v[3]);
      end
      pulse_play(3);
      checks++;
      if (per_v[3] !== 32'd40 || out_v[3] !== 1'b1) begin
         errors++;
         $display("FAIL retrig_reload: per=%0d out=%b want 40 1", per_v[3], out_v[3]);
      end
      for (int c = 0; c < 80; c++) begin
         if (c > 0) @(negedge clk);
         if (act_v[3] === 1'b1) act_cycles++;
         checks++;
         if (out_v[3] !== m_out[3] || 64'(per_v[3]) !== m_per[3]) begin
            errors++;
            $display("FAIL retrig_model c%0d: out=%b per=%0d want %b %0d", c, out_v[3], per_v[3], m_out[3], m_per[3]);
         end
      end
      checks++;
      if (act_cycles != 60) begin
         errors++;
         $display("FAIL retrig_duration: active cycles=%0d want 60", act_cycles);
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) begin
            play_v[i] = ($urandom_range(47) == 0);
            stop_v[i] = ($urandom_range(97) == 0);
         end
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_v[i] !== m_out[i] || act_v[i] !== m_act[i] || 64'(per_v[i]) !== m_per[i]) begin
               errors++;
               if (bad < 10)
                  $display("FAIL random c%0d v%0d: out=%b act=%b per=%0d want %b %b %0d",
                           c, i, out_v[i], act_v[i], per_v[i], m_out[i], m_act[i], m_per[i]);
               bad++;
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         play_v[i] = 1'b0;
         stop_v[i] = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         play_v[i] = 1'b0;
         stop_v[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_tone();
      test_loop_stop();
      test_sweep();
      test_retrigger();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
